// File: rtl/sm4_sbox.sv
// -----------------------------------------------------------------------------
// sm4_sbox
// Registered SM4 (GB/T 32907) byte substitution box with a start/finish
// handshake. One byte per clock throughput, one clock latency.
//
// Optional feature macro: SM4_SBOX_MASK_EN
//   When defined, an extra mask input m[7:0] follows x. The input x is then
//   treated as a masked byte (v ^ m). The result is re-masked with the same
//   mask: s_out1 = SBOX[x ^ m] ^ m.
// -----------------------------------------------------------------------------
module sm4_sbox (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] x,
`ifdef SM4_SBOX_MASK_EN
    input  logic [7:0] m,
`endif
    output logic       finish,
    output logic [7:0] s_out1
);

    // Standard SM4 substitution table, row = x[7:4], column = x[3:0].
    localparam logic [7:0] SBOX_ROM [0:255] = '{
        8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
        8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
        8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
        8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
        8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
        8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
        8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
        8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
        8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
        8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
        8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
        8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
        8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
        8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
    };

    // ROM lookup of one byte.
    function automatic logic [7:0] sbox_lookup(input logic [7:0] idx);
        return SBOX_ROM[idx];
    endfunction

    logic       finish_q;
    logic       finish_d;
    logic [7:0] sout_q;
    logic [7:0] sout_d;
    logic [7:0] sub_s;

`ifdef SM4_SBOX_MASK_EN
    // Unmask, substitute, then re-apply the same mask to the result.
    always_comb begin
        sub_s = sbox_lookup(x ^ m) ^ m;
    end
`else
    // Plain substitution of the input byte.
    always_comb begin
        sub_s = sbox_lookup(x);
    end
`endif

    // Next-state: a start strobe loads a new result; otherwise the data holds.
    always_comb begin
        finish_d = 1'b0;
        sout_d   = sout_q;
        if (start == 1'b1) begin
            finish_d = 1'b1;
            sout_d   = sub_s;
        end else begin
            finish_d = 1'b0;
            sout_d   = sout_q;
        end
    end

    // Output registers with synchronous active-low reset taking priority over start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            finish_q <= 1'b0;
            sout_q   <= 8'h00;
        end else begin
            finish_q <= finish_d;
            sout_q   <= sout_d;
        end
    end

    assign finish = finish_q;
    assign s_out1 = sout_q;

endmodule

// File: tb/tb_sm4_sbox.sv
// -----------------------------------------------------------------------------
// tb_sm4_sbox
// Self-checking bench for sm4_sbox. A behavioural model tracks what finish and
// s_out1 must be after each rising edge; a compare process checks the DUT on
// every falling edge. Literal expectations pin the model to known S-box values.
// Define SM4_SBOX_MASK_EN to exercise the masked variant.
// -----------------------------------------------------------------------------
module tb_sm4_sbox;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] x;
    logic [7:0] m;
    logic       finish;
    logic [7:0] s_out1;

    int tests;
    int fails;

    // Reference S-box (GB/T 32907).
    logic [7:0] ref_tab [0:255] = '{
        8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
        8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
        8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
        8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
        8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
        8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
        8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
        8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
        8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
        8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
        8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
        8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
        8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
        8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
    };

    sm4_sbox dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x      (x),
`ifdef SM4_SBOX_MASK_EN
        .m      (m),
`endif
        .finish (finish),
        .s_out1 (s_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What a request on byte xv with mask mv must return.
    function automatic logic [7:0] model_sub(input logic [7:0] xv, input logic [7:0] mv);
`ifdef SM4_SBOX_MASK_EN
        return ref_tab[xv ^ mv] ^ mv;
`else
        return ref_tab[xv] ^ (mv & 8'h00);
`endif
    endfunction

    // Behavioural model: expected outputs after each rising edge.
    logic       exp_f;
    logic [7:0] exp_s;
    logic       model_ok;
    initial begin
        exp_f    = 1'b0;
        exp_s    = 8'h00;
        model_ok = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n == 1'b0) begin
            exp_f    = 1'b0;
            exp_s    = 8'h00;
            model_ok = 1'b1;
        end else if (start == 1'b1) begin
            exp_f = 1'b1;
            exp_s = model_sub(x, m);
        end else begin
            exp_f = 1'b0;
        end
    end

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
        end
    endtask

    // Compare process: every falling edge once the model has seen a reset.
    always @(negedge clk) begin
        if (model_ok) begin
            check1("finish", finish, exp_f);
            check8("s_out1", s_out1, exp_s);
        end
    end

    task automatic drive(input logic rs, input logic st, input logic [7:0] xv, input logic [7:0] mv);
        @(negedge clk);
        rst_n = rs;
        start = st;
        x     = xv;
        m     = mv;
    endtask

    // Drive one unmasked request and compare the result against a literal.
    task automatic pin(input string name, input logic [7:0] xv, input logic [7:0] want);
        drive(1'b1, 1'b1, xv, 8'h00);
        @(posedge clk);
        #1;
        check1({name, "_fin"}, finish, 1'b1);
        check8(name, s_out1, want);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b1;
        x     = 8'h00;
        m     = 8'h00;

        // Long reset with requests pending: all dropped.
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 1'b1, 8'($urandom), 8'h00);
        end
        @(posedge clk);
        #1;
        check1("rst_fin", finish, 1'b0);
        check8("rst_sout", s_out1, 8'h00);

        // First lookup after reset and single shot.
        pin("lit_00", 8'h00, 8'hD6);
        pin("lit_ff", 8'hFF, 8'h48);
        drive(1'b1, 1'b0, 8'h12, 8'h00);
        @(posedge clk);
        #1;
        check1("shot_fin_low", finish, 1'b0);
        check8("shot_hold", s_out1, 8'h48);

        // Back-to-back literal pins.
        pin("lit_01", 8'h01, 8'h90);
        pin("lit_02", 8'h02, 8'hE9);
        pin("lit_03", 8'h03, 8'hFE);
        pin("lit_10", 8'h10, 8'h2B);

        // Streaming sweep 00..FF, checked by the compare process.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b1, 8'(i), 8'h00);
        end

        // Idle sweep: output must hold the last streamed value.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, 8'(i), 8'h00);
        end
        @(posedge clk);
        #1;
        check8("idle_hold", s_out1, 8'h48);

        // Reset for one edge in the middle of a stream.
        for (int i = 0; i < 20; i++) begin
            drive((i == 10) ? 1'b0 : 1'b1, 1'b1, 8'($urandom), 8'h00);
        end

`ifdef SM4_SBOX_MASK_EN
        drive(1'b1, 1'b1, 8'hB5, 8'hA5);
        @(posedge clk);
        #1;
        check1("mask_fin", finish, 1'b1);
        check8("mask_lit", s_out1, 8'h8E);
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        drive(1'b1, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
